fifo_rd_lane_unpacker: RTL and testbench
========================================

// Module: fifo_rd_lane_unpacker
// PURPOSE
//   Read-side master for a standard-mode FIFO (rddata valid 1 cycle after rden). Pulls IF_WIDTH-bit
//   words and emits them as DIVISOR narrow lanes on a valid/ready stream, in configurable lane order.
//   Sits at the drain end of the FIFOs our write-side lane reorder fills; undoes that lane reversal
//   lane-by-lane. Prefetches one word so the stream sustains 1 lane/clk for DIVISOR>=2.
// PARAMETERS
//   IF_WIDTH    256        FIFO word width; must be divisible by DIVISOR, else elaboration error
//   DIVISOR     8          lanes per word; BASE_WIDTH = IF_WIDTH/DIVISOR
//   LANE_ORDER  "REVERSE"  "REVERSE": lane k = word[BASE_WIDTH*(DIVISOR-1-k) +: BASE_WIDTH] (MSB lane first);
//                          "NATURAL": lane k = word[BASE_WIDTH*k +: BASE_WIDTH]
// PORTS
//   clk                 in   1           single clock
//   rst_n               in   1           asynchronous, active-low reset
//   fifo_rddata         in   IF_WIDTH    FIFO read data, valid the cycle after fifo_rden
//   fifo_rden           out  1           FIFO read strobe
//   fifo_empty          in   1           FIFO empty
//   fifo_almostempty    in   1           unused; kept for interface completeness
//   m_data              out  BASE_WIDTH  current lane
//   m_valid             out  1           m_data valid
//   m_ready             in   1           downstream accept; transfer = m_valid & m_ready
//   m_last              out  1           high on the last lane (lane DIVISOR-1) of a word
//   busy                out  1           any word held or read in flight
// BEHAVIOUR
//   Storage: holding reg HR (+hr_vld, lane_cnt 0..DIVISOR-1), pending reg PR (+pr_vld), rd_inflight (= fifo_rden delayed 1).
//   Reset (async, rst_n=0): hr_vld=pr_vld=rd_inflight=0, lane_cnt=0; fifo_rden=0, m_valid=0, m_last=0, busy=0,
//     m_data=0. An in-flight word is discarded; FIFO must be reset in the same domain reset.
//   fifo_rden = !fifo_empty & (hr_vld + pr_vld + rd_inflight < 2); combinational from registers + fifo_empty.
//   Never asserts fifo_rden while fifo_empty=1. Never overflows storage (at most 2 words owned incl. in-flight).
//   Capture (rd_inflight=1): into HR if HR empty or HR's last lane transfers this cycle and pr_vld=0; else into PR.
//   HR advance on transfer: lane_cnt++; on last lane: lane_cnt=0, HR<=PR if pr_vld (pr_vld=0), else HR<=captured
//     data if rd_inflight, else hr_vld=0. Simultaneous PR->HR and capture: captured data goes to PR.
//   m_valid = hr_vld; m_data = lane(HR, lane_cnt) per LANE_ORDER; m_last = hr_vld & (lane_cnt==DIVISOR-1).
//   Backpressure: m_ready=0 holds m_data/m_last/lane_cnt stable; prefetch continues until storage full.
//   Latency: fifo_empty falls in cycle 0 -> fifo_rden cycle 0 -> m_valid=1 with lane 0 in cycle 2.
//   Throughput: DIVISOR>=2 with m_ready=1 and FIFO non-empty -> m_valid continuously 1, no bubble between words.
//     DIVISOR=1: correct but may bubble (max 2 words per 3 clk); not a supported perf point.
//   busy = hr_vld | pr_vld | rd_inflight.
// STRUCTURE
//   Package fifo_if_pkg: LANE_ORDER string constants, clog2 function for lane_cnt width.
//   Sub-module fifo_if_lane_mux (combinational lane select from word, index, LANE_ORDER), reusable by a
//   future write-side lane packer. Control (occupancy, capture steering, lane_cnt) stays in this module.
// TESTING
//   1. Reset, fifo_empty=1 for 20 clk -> fifo_rden never 1, m_valid=0, busy=0.
//   2. IF_WIDTH=256, DIVISOR=8, REVERSE; one word 0x1F1E..00 (32 bytes) -> fifo_rden in cycle 0, m_valid in cycle 2,
//      lanes out 0x1F1E1D1C, 0x1B1A1918 ... 0x03020100; m_last only on 8th lane; busy=0 after it.
//   3. 4 words back-to-back, m_ready=1 -> 32 consecutive lane transfers, zero m_valid gaps, fifo_rden <=4 pulses.
//   4. m_ready toggled random 50% while 6 words stream -> m_data stable while m_valid & !m_ready; no loss/dup;
//      fifo_rden never asserted when 2 words held/in flight.
//   5. NATURAL order, word 0x..0100 -> first lane 0x03020100; DIVISOR=2 sustained run: no bubbles.
//   6. rst_n pulled low mid-word (lane 3) with one read in flight -> all outputs 0 asynchronously; after release
//      and FIFO refill, next word restarts at lane 0 with correct data.

Source files
------------

// File: rtl/fifo_if_pkg.sv
// Shared definitions for the FIFO interface lane blocks: lane-order names and counter sizing.
package fifo_if_pkg;

  localparam string LANE_REVERSE = "REVERSE";
  localparam string LANE_NATURAL = "NATURAL";

  // Width of a lane index counter; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_if_lane_mux.sv
// Combinational lane select: picks lane idx of a wide FIFO word in the configured lane order.
module fifo_if_lane_mux
  import fifo_if_pkg::*;
#(
  parameter int unsigned IF_WIDTH   = 256,
  parameter int unsigned DIVISOR    = 8,
  parameter string       LANE_ORDER = "REVERSE"
) (
  input  logic [IF_WIDTH-1:0]                    word,
  input  logic [clog2_min1(DIVISOR)-1:0]         idx,
  output logic [IF_WIDTH/DIVISOR-1:0]            lane_c
);

  localparam int unsigned BASE_WIDTH = IF_WIDTH / DIVISOR;
  localparam int unsigned CNT_W      = clog2_min1(DIVISOR);
  localparam bit          REV        = (LANE_ORDER == LANE_REVERSE);

  if (LANE_ORDER != LANE_REVERSE && LANE_ORDER != LANE_NATURAL) begin : g_order_check
    $error("fifo_if_lane_mux: LANE_ORDER must be REVERSE or NATURAL");
  end

  // REVERSE puts the most significant lane first on the stream.
  always_comb begin
    lane_c = '0;
    for (int unsigned k = 0; k < DIVISOR; k++) begin
      if (idx == CNT_W'(k)) begin
        lane_c = word[BASE_WIDTH*(REV ? (DIVISOR-1-k) : k) +: BASE_WIDTH];
      end
    end
  end

endmodule

// File: rtl/fifo_rd_lane_unpacker.sv
// Read-side FIFO master: prefetches words into a holding/pending pair and streams them out lane by lane.
module fifo_rd_lane_unpacker
  import fifo_if_pkg::*;
#(
  parameter int unsigned IF_WIDTH   = 256,
  parameter int unsigned DIVISOR    = 8,
  parameter string       LANE_ORDER = "REVERSE"
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [IF_WIDTH-1:0]         fifo_rddata,
  output logic                        fifo_rden,
  input  logic                        fifo_empty,
  input  logic                        fifo_almostempty,
  output logic [IF_WIDTH/DIVISOR-1:0] m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last,
  output logic                        busy
);

  localparam int unsigned CNT_W = clog2_min1(DIVISOR);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(DIVISOR - 1);

  if (IF_WIDTH % DIVISOR != 0) begin : g_width_check
    $error("fifo_rd_lane_unpacker: IF_WIDTH must be divisible by DIVISOR");
  end

  logic [IF_WIDTH-1:0] hr;
  logic [IF_WIDTH-1:0] pr;
  logic                hr_vld;
  logic                pr_vld;
  logic                rd_inflight;
  logic [CNT_W-1:0]    lane_cnt;
  logic [1:0]          occupancy;
  logic                xfer;
  logic                last_xfer;
  logic                unused_almostempty;

  assign unused_almostempty = fifo_almostempty;

  // Words owned include the one in flight, so storage can never be overrun.
  assign occupancy = 2'(hr_vld) + 2'(pr_vld) + 2'(rd_inflight);
  assign fifo_rden = rst_n & ~fifo_empty & (occupancy < 2'd2);

  assign xfer      = hr_vld & m_ready;
  assign last_xfer = xfer & (lane_cnt == LAST_LANE);

  assign m_valid = hr_vld;
  assign m_last  = hr_vld & (lane_cnt == LAST_LANE);
  assign busy    = hr_vld | pr_vld | rd_inflight;

  fifo_if_lane_mux #(
    .IF_WIDTH   (IF_WIDTH),
    .DIVISOR    (DIVISOR),
    .LANE_ORDER (LANE_ORDER)
  ) u_lane_mux (
    .word   (hr),
    .idx    (lane_cnt),
    .lane_c (m_data)
  );

  // Capture steering: a word finishing this cycle hands HR to PR (if held) or to the arriving word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hr          <= '0;
      pr          <= '0;
      hr_vld      <= 1'b0;
      pr_vld      <= 1'b0;
      rd_inflight <= 1'b0;
      lane_cnt    <= '0;
    end else begin
      rd_inflight <= fifo_rden;
      if (last_xfer) begin
        lane_cnt <= '0;
        if (pr_vld) begin
          hr     <= pr;
          pr_vld <= rd_inflight;
          if (rd_inflight) pr <= fifo_rddata;
        end else if (rd_inflight) begin
          hr <= fifo_rddata;
        end else begin
          hr_vld <= 1'b0;
        end
      end else begin
        if (xfer) lane_cnt <= lane_cnt + CNT_W'(1);
        if (rd_inflight) begin
          if (!hr_vld) begin
            hr     <= fifo_rddata;
            hr_vld <= 1'b1;
          end else begin
            pr     <= fifo_rddata;
            pr_vld <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_lane_unpacker.sv
// Directed bench for fifo_rd_lane_unpacker: REVERSE 256/8 instance plus a NATURAL 64/2 instance.
module tb_fifo_rd_lane_unpacker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic almostempty = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- instance A: 256-bit, 8 lanes, REVERSE ----------------
  logic [255:0] a_rddata = '0;
  logic         a_rden, a_empty, a_valid, a_last, a_busy;
  logic         a_ready = 1'b0;
  logic [31:0]  a_data;
  logic [255:0] a_mem [0:63];
  int           a_wp = 0, a_rp = 0;
  assign a_empty = (a_wp == a_rp);

  fifo_rd_lane_unpacker #(.IF_WIDTH(256), .DIVISOR(8), .LANE_ORDER("REVERSE")) dut_a (
    .clk(clk), .rst_n(rst_n), .fifo_rddata(a_rddata), .fifo_rden(a_rden),
    .fifo_empty(a_empty), .fifo_almostempty(almostempty), .m_data(a_data),
    .m_valid(a_valid), .m_ready(a_ready), .m_last(a_last), .busy(a_busy));

  // ---------------- instance B: 64-bit, 2 lanes, NATURAL ----------------
  logic [63:0]  b_rddata = '0;
  logic         b_rden, b_empty, b_valid, b_last, b_busy;
  logic         b_ready = 1'b1;
  logic [31:0]  b_data;
  logic [63:0]  b_mem [0:15];
  int           b_wp = 0, b_rp = 0;
  assign b_empty = (b_wp == b_rp);

  fifo_rd_lane_unpacker #(.IF_WIDTH(64), .DIVISOR(2), .LANE_ORDER("NATURAL")) dut_b (
    .clk(clk), .rst_n(rst_n), .fifo_rddata(b_rddata), .fifo_rden(b_rden),
    .fifo_empty(b_empty), .fifo_almostempty(almostempty), .m_data(b_data),
    .m_valid(b_valid), .m_ready(b_ready), .m_last(b_last), .busy(b_busy));

  // Standard-mode FIFO models: data appears the cycle after rden; reset flushes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rp <= a_wp;
      b_rp <= b_wp;
    end else begin
      if (a_rden) begin a_rddata <= a_mem[a_rp]; a_rp <= a_rp + 1; end
      if (b_rden) begin b_rddata <= b_mem[b_rp]; b_rp <= b_rp + 1; end
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected-lane scoreboard for A, built from the lane-order definition.
  logic [31:0] exp_d [$];
  logic        exp_l [$];
  logic [31:0] a_got [$];
  logic        a_got_l [$];
  logic [31:0] b_got [$];
  logic        b_got_l [$];
  int          owned = 0;
  logic        a_pv = 0, a_pr = 0, a_pl = 0;
  logic [31:0] a_pd = '0;

  task automatic push_a(input logic [255:0] w);
    a_mem[a_wp] = w;
    a_wp++;
    for (int k = 0; k < 8; k++) begin
      exp_d.push_back(w[32*(7-k) +: 32]);
      exp_l.push_back(k == 7);
    end
  endtask

  task automatic push_b(input logic [63:0] w);
    b_mem[b_wp] = w;
    b_wp++;
  endtask

  function automatic logic [255:0] rand_word();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom();
    return w;
  endfunction

  // Per-cycle monitor, sampled after the falling edge; a transfer happens at the next rising edge.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      owned = 0;
      a_pv  = 1'b0;
      exp_d.delete();
      exp_l.delete();
    end else begin
      chk("a_rden_while_empty", 256'(a_rden & a_empty), '0);
      chk("a_rden_when_full", 256'(a_rden && owned >= 2), '0);
      chk("a_busy", 256'(a_busy), 256'(owned != 0));
      chk("b_rden_while_empty", 256'(b_rden & b_empty), '0);
      if (a_pv && !a_pr) begin
        chk("a_hold_data", 256'(a_data), 256'(a_pd));
        chk("a_hold_last", 256'(a_last), 256'(a_pl));
      end
      if (a_valid && a_ready) begin
        a_got.push_back(a_data);
        a_got_l.push_back(a_last);
        if (exp_d.size() == 0) begin
          chk("a_unexpected_lane", 256'(1), '0);
        end else begin
          logic el;
          el = exp_l.pop_front();
          chk("a_lane_data", 256'(a_data), 256'(exp_d.pop_front()));
          chk("a_lane_last", 256'(a_last), 256'(el));
          if (el) owned--;
        end
      end
      if (a_rden) owned++;
      if (b_valid && b_ready) begin
        b_got.push_back(b_data);
        b_got_l.push_back(b_last);
      end
      a_pv = a_valid; a_pr = a_ready; a_pd = a_data; a_pl = a_last;
    end
  end

  // Runs ncyc cycles from a falling edge with m_ready=1 and profiles rden/valid on A.
  task automatic run_a(input int ncyc, output int rden_cnt, output int first_r,
                       output int vcnt, output int first_v, output int last_v);
    rden_cnt = 0; first_r = -1; vcnt = 0; first_v = -1; last_v = -1;
    for (int c = 0; c < ncyc; c++) begin
      #1;
      if (a_rden) begin rden_cnt++; if (first_r < 0) first_r = c; end
      if (a_valid) begin vcnt++; if (first_v < 0) first_v = c; last_v = c; end
      @(negedge clk);
    end
  endtask

  typedef struct { logic [31:0] d; logic l; } lane_vec_t;
  typedef struct { logic [63:0] w; logic [31:0] l0; logic [31:0] l1; } nat_vec_t;

  initial begin
    lane_vec_t    tv [8];
    nat_vec_t     nv [4];
    logic [255:0] w0;
    int rc, fr, vc, fv, lv;

    tv[0] = '{32'h1F1E1D1C, 1'b0}; tv[1] = '{32'h1B1A1918, 1'b0};
    tv[2] = '{32'h17161514, 1'b0}; tv[3] = '{32'h13121110, 1'b0};
    tv[4] = '{32'h0F0E0D0C, 1'b0}; tv[5] = '{32'h0B0A0908, 1'b0};
    tv[6] = '{32'h07060504, 1'b0}; tv[7] = '{32'h03020100, 1'b1};
    nv[0] = '{64'h07060504_03020100, 32'h03020100, 32'h07060504};
    nv[1] = '{64'hDEADBEEF_CAFEF00D, 32'hCAFEF00D, 32'hDEADBEEF};
    nv[2] = '{64'h00000001_FFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    nv[3] = '{64'h80000000_00000000, 32'h00000000, 32'h80000000};
    for (int i = 0; i < 32; i++) w0[8*i +: 8] = 8'(i);

    // 1. reset state, then idle with an empty FIFO
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 256'(a_valid), '0);
    chk("rst_busy", 256'(a_busy), '0);
    chk("rst_data", 256'(a_data), '0);
    chk("rst_last", 256'(a_last), '0);
    @(negedge clk);
    rst_n = 1'b1;
    a_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #2;
      chk("idle_rden", 256'(a_rden), '0);
      chk("idle_valid", 256'(a_valid), '0);
      chk("idle_busy", 256'(a_busy), '0);
    end
    @(negedge clk);

    // 2. one word, REVERSE order, latency and lane table
    a_got.delete(); a_got_l.delete();
    push_a(w0);
    run_a(16, rc, fr, vc, fv, lv);
    chk("t2_rden_cycle", 256'(fr), 256'(0));
    chk("t2_rden_pulses", 256'(rc), 256'(1));
    chk("t2_valid_cycle", 256'(fv), 256'(2));
    chk("t2_lane_count", 256'(vc), 256'(8));
    chk("t2_busy_after", 256'(a_busy), '0);
    chk("t2_got_size", 256'(a_got.size()), 256'(8));
    for (int k = 0; k < 8 && k < a_got.size(); k++) begin
      chk($sformatf("t2_lane%0d_data", k), 256'(a_got[k]), 256'(tv[k].d));
      chk($sformatf("t2_lane%0d_last", k), 256'(a_got_l[k]), 256'(tv[k].l));
    end

    // 3. four words back-to-back, no bubbles
    for (int i = 0; i < 4; i++) push_a(rand_word());
    run_a(50, rc, fr, vc, fv, lv);
    chk("t3_transfers", 256'(vc), 256'(32));
    chk("t3_no_gaps", 256'(lv - fv + 1), 256'(32));
    chk("t3_rden_pulses", 256'(rc), 256'(4));
    chk("t3_drained", 256'(exp_d.size()), '0);

    // 4. random backpressure over six words
    for (int i = 0; i < 6; i++) push_a(rand_word());
    for (int c = 0; c < 400 && (exp_d.size() != 0 || a_busy); c++) begin
      a_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    a_ready = 1'b1;
    #1;
    chk("t4_drained", 256'(exp_d.size()), '0);
    chk("t4_busy_after", 256'(a_busy), '0);
    @(negedge clk);

    // 5. NATURAL order on the 2-lane instance, sustained
    b_got.delete(); b_got_l.delete();
    for (int i = 0; i < 4; i++) push_b(nv[i].w);
    fv = -1; lv = -1; vc = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (b_valid) begin vc++; if (fv < 0) fv = c; lv = c; end
      @(negedge clk);
    end
    chk("t5_transfers", 256'(vc), 256'(8));
    chk("t5_no_gaps", 256'(lv - fv + 1), 256'(8));
    chk("t5_busy_after", 256'(b_busy), '0);
    chk("t5_got_size", 256'(b_got.size()), 256'(8));
    for (int i = 0; i < 4 && 2*i+1 < b_got.size(); i++) begin
      chk($sformatf("t5_w%0d_lane0", i), 256'(b_got[2*i]), 256'(nv[i].l0));
      chk($sformatf("t5_w%0d_lane1", i), 256'(b_got[2*i+1]), 256'(nv[i].l1));
      chk($sformatf("t5_w%0d_last0", i), 256'(b_got_l[2*i]), '0);
      chk($sformatf("t5_w%0d_last1", i), 256'(b_got_l[2*i+1]), 256'(1));
    end

    // 6. async reset mid-word (lane 3 held, next read in flight), then restart
    push_a(w0);
    repeat (5) @(negedge clk);
    a_ready = 1'b0;
    push_a(~w0);
    @(negedge clk);
    #1;
    chk("t6_lane3_held", 256'(a_data), 256'(32'h13121110));
    chk("t6_busy_before", 256'(a_busy), 256'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rden", 256'(a_rden), '0);
    chk("t6_rst_valid", 256'(a_valid), '0);
    chk("t6_rst_last", 256'(a_last), '0);
    chk("t6_rst_busy", 256'(a_busy), '0);
    chk("t6_rst_data", 256'(a_data), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_ready = 1'b1;
    a_got.delete(); a_got_l.delete();
    push_a(~w0);
    run_a(14, rc, fr, vc, fv, lv);
    chk("t6_valid_cycle", 256'(fv), 256'(2));
    chk("t6_lane_count", 256'(vc), 256'(8));
    chk("t6_first_lane", 256'(a_got.size() > 0 ? a_got[0] : 32'h0), 256'(32'hE0E1E2E3));
    chk("t6_drained", 256'(exp_d.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
